// File: rtl/ntru_pkg.sv
// Shared constants and the sequencer state encoding for the NTRU-HRSS polynomial datapath.
package ntru_pkg;

  localparam int N_DEF      = 701;
  localparam int COEF_W_DEF = 13;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/add_2i13_o13.sv
// 13-bit two-input Kogge-Stone prefix adder; the result wraps mod 2^13 and the carry out is not produced.
module add_2i13_o13 (
  input  logic [12:0] i_a,
  input  logic [12:0] i_b,
  output logic [12:0] o_sum
);

  logic [12:0] w_p0;
  logic [12:0] w_g;
  logic [12:0] w_p;

  assign w_p0 = i_a ^ i_b;

  // Descending index order lets each level read the previous level's values in place.
  always_comb begin
    w_g = i_a & i_b;
    w_p = w_p0;
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = 12; i >= 0; i--) begin
        if (i >= (1 << lvl)) begin
          w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
          w_p[i] = w_p[i] & w_p[i - (1 << lvl)];
        end
      end
    end
  end

  always_comb begin
    o_sum    = '0;
    o_sum[0] = w_p0[0];
    for (int i = 1; i < 13; i++) begin
      o_sum[i] = w_p0[i] ^ w_g[i - 1];
    end
  end

endmodule

// File: rtl/poly_add_fifo2.sv
// Two-entry FIFO holding {address, coefficient} results between the adder and the result RAM.
module poly_add_fifo2 #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_pop;

  assign w_do_pop = i_pop && (r_count != 2'd0);
  assign o_data   = r_mem[r_rd_ptr];
  assign o_valid  = (r_count != 2'd0);
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) r_mem[k] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_do_pop};
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && r_count == 2'd2));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(i_pop && r_count == 2'd0));

endmodule

// File: rtl/poly_add_seq.sv
// Streams a[i], b[i] out of two sync RAMs through one 13-bit prefix adder and writes
// c[i] = (a[i] + b[i]) mod 2^13 to a result RAM in ascending address order.
module poly_add_seq
  import ntru_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] rd_data_a,
  input  logic [COEF_W-1:0] rd_data_b,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COEF_W-1:0] wr_data,
  output logic [1:0]        dbg_state
);

  localparam int                EW        = ADDR_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  seq_state_t        r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;

  logic [COEF_W-1:0] w_sum;
  logic [EW-1:0]     w_head;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic              w_pop;
  logic [2:0]        w_occupancy;
  logic              w_rd_en;
  logic              w_last_write;

  // Result handshake: a word moves to RAM C on a cycle with wr_valid && wr_ready; while
  // wr_valid is high and wr_ready low, wr_addr/wr_data hold and wr_valid is not withdrawn.
  assign w_pop = w_fifo_valid && wr_ready;

  // A slot being popped this cycle already counts as free, which sustains one read per cycle
  // when wr_ready stays high while still never issuing a read the FIFO cannot absorb.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en     = (r_state == ST_RUN) && (w_occupancy < 3'd2);

  assign w_last_write = w_pop && (wr_addr == LAST_ADDR);

  add_2i13_o13 u_add (
    .i_a   (rd_data_a),
    .i_b   (rd_data_b),
    .o_sum (w_sum)
  );

  poly_add_fifo2 #(.W(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_addr, w_sum}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_addr <= r_rd_addr;
      r_done          <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        ST_RUN: begin
          if (w_rd_en) begin
            if (r_rd_addr == LAST_ADDR) r_state <= ST_DRAIN;
            else r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_last_write) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = w_rd_en;
  assign rd_addr   = r_rd_addr;
  assign wr_valid  = w_fifo_valid;
  assign wr_addr   = w_head[EW-1:COEF_W];
  assign wr_data   = w_head[COEF_W-1:0];
  assign dbg_state = r_state;

  a_rd_addr_range: assert property (@(posedge clk) disable iff (!rst_n) rd_en |-> (rd_addr <= LAST_ADDR));

endmodule

// File: tb/tb_poly_add_seq.sv
// Bench for poly_add_seq: RAM model, randomized data and back-pressure, scoreboard of expected writes.
module tb_poly_add_seq;

  localparam int N      = 701;
  localparam int COEF_W = 13;
  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + COEF_W;
  localparam int BUDGET = 4000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COEF_W-1:0] rd_data_a;
  logic [COEF_W-1:0] rd_data_b;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic [1:0]        dbg_state;

  poly_add_seq #(.N(N), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns, expected finish");
    $fatal(1, "watchdog");
  end

  // RAM contents and scoreboard state
  int                ram_a [N];
  int                ram_b [N];
  int                obs_c [N];
  logic [EW-1:0]     exp_q [$];
  int                vectors;
  int                miscompares;
  int                cyc;
  int                start_cyc;
  int                reads;
  int                writes;
  int                exp_rd_addr;
  int                done_cnt;
  int                done_rel;
  int                first_wv_rel;
  int                stall_late_reads;
  int                stall_out;
  logic              busy_k0;
  logic              busy_k1;
  logic              obs_busy;
  logic              obs_done;
  logic              obs_rd_en;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [COEF_W-1:0] prev_data;

  task automatic load_mem(input int kind);
    logic [EW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: begin ram_a[i] = i; ram_b[i] = 2 * i; end
        1: begin
          if (i % 2 == 0) begin ram_a[i] = 8191; ram_b[i] = 1; end
          else begin ram_a[i] = 5000; ram_b[i] = 4000; end
        end
        default: begin
          ram_a[i] = int'($urandom_range(0, 8191));
          ram_b[i] = int'($urandom_range(0, 8191));
        end
      endcase
      e = {ADDR_W'(i), COEF_W'((ram_a[i] + ram_b[i]) % 8192)};
      exp_q.push_back(e);
      obs_c[i] = -1;
    end
  endtask

  // One clock: drive at posedge+1, observe and score at the falling edge, answer reads next cycle.
  task automatic do_cycle(input logic rdy, input logic st);
    logic [EW-1:0] e;
    logic          acc;
    wr_ready = rdy;
    start    = st;
    #4;
    obs_rd_en = rd_en;
    obs_busy  = busy;
    obs_done  = done;
    if (first_wv_rel < 0 && wr_valid === 1'b1) first_wv_rel = cyc - start_cyc;
    if (rd_en === 1'b1) begin
      vectors++;
      if (int'(rd_addr) !== exp_rd_addr) begin
        miscompares++;
        $display("FAIL rd_addr: got %0d expected %0d", rd_addr, exp_rd_addr);
      end
      exp_rd_addr++;
      reads++;
    end
    if (prev_stall) begin
      vectors++;
      if (wr_valid !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%0b addr=%0d data=%0d expected valid=1 addr=%0d data=%0d",
                 wr_valid, wr_addr, wr_data, prev_addr, prev_data);
      end
    end
    acc = (wr_valid === 1'b1) && rdy;
    if (acc) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_write: got addr=%0d data=%0d expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   wr_addr, wr_data, e[EW-1:COEF_W], e[COEF_W-1:0]);
        end
      end
      if (int'(wr_addr) < N) obs_c[int'(wr_addr)] = int'(wr_data);
      writes++;
    end
    vectors++;
    if (reads - writes > 2) begin
      miscompares++;
      $display("FAIL outstanding: got %0d expected at most 2", reads - writes);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
    prev_stall = (wr_valid === 1'b1) && !rdy;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    pend       = (rd_en === 1'b1);
    pend_addr  = rd_addr;
    @(posedge clk);
    #1;
    rd_data_a = pend ? COEF_W'(ram_a[int'(pend_addr)]) : COEF_W'($urandom);
    rd_data_b = pend ? COEF_W'(ram_b[int'(pend_addr)]) : COEF_W'($urandom);
    cyc++;
  endtask

  // mode 0: ready always high; 1: ready low ~30% of cycles; 2: ready low for 50 cycles from stall_at.
  task automatic run_op(input int mode, input int stall_at, input int extra_st, input int extra_st2,
                        input int abort_writes);
    logic rdy;
    bit   fin;
    reads = 0; writes = 0; exp_rd_addr = 0; done_cnt = 0; done_rel = -1; first_wv_rel = -1;
    stall_late_reads = 0; stall_out = -1; start_cyc = cyc; fin = 0;
    do_cycle(1'b1, 1'b1);
    busy_k0 = obs_busy;
    for (int k = 1; k < BUDGET && !fin; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 99) >= 30);
        default: rdy = !(k >= stall_at && k < stall_at + 50);
      endcase
      do_cycle(rdy, (k == extra_st) || (k == extra_st2));
      if (k == 1) busy_k1 = obs_busy;
      if (mode == 2 && k >= stall_at + 3 && k < stall_at + 50 && obs_rd_en) stall_late_reads++;
      if (mode == 2 && k == stall_at + 49) stall_out = reads - writes;
      if (done_cnt > 0 || (abort_writes > 0 && writes >= abort_writes)) fin = 1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0; rd_data_a = '0; rd_data_b = '0;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, rd_en, wr_valid} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, rd_en, wr_valid});
    end
    vectors++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      miscompares++;
      $display("FAIL reset_buses: got rd_addr=%0d wr_addr=%0d wr_data=%0d expected 0 0 0", rd_addr, wr_addr, wr_data);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #4;
    vectors++;
    if ({busy, rd_en, wr_valid} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, rd_en, wr_valid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    load_mem(0);
    run_op(0, 0, -1, -1, 0);
    vectors++;
    if (done_rel !== N + 3) begin
      miscompares++;
      $display("FAIL ramp_done_time: got %0d expected %0d", done_rel, N + 3);
    end
    vectors++;
    if (first_wv_rel !== 3) begin
      miscompares++;
      $display("FAIL ramp_first_valid: got %0d expected 3", first_wv_rel);
    end
    vectors++;
    if (busy_k0 !== 1'b0 || busy_k1 !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_busy: got k0=%0b k1=%0b expected k0=0 k1=1", busy_k0, busy_k1);
    end
    vectors++;
    if (writes !== N || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL ramp_count: got %0d writes, %0d left expected %0d, 0", writes, exp_q.size(), N);
    end
    vectors++;
    if (obs_c[N-1] !== 3 * (N - 1)) begin
      miscompares++;
      $display("FAIL ramp_last: got %0d expected %0d", obs_c[N-1], 3 * (N - 1));
    end
  endtask

  task automatic test_wrap();
    load_mem(1);
    run_op(0, 0, -1, -1, 0);
    vectors++;
    if (obs_c[0] !== 0 || obs_c[N-1] !== 0) begin
      miscompares++;
      $display("FAIL wrap_8191_1: got %0d,%0d expected 0,0", obs_c[0], obs_c[N-1]);
    end
    vectors++;
    if (obs_c[1] !== 808) begin
      miscompares++;
      $display("FAIL wrap_5000_4000: got %0d expected 808", obs_c[1]);
    end
    vectors++;
    if (writes !== N || done_rel !== N + 3) begin
      miscompares++;
      $display("FAIL wrap_done: got writes=%0d t=%0d expected %0d %0d", writes, done_rel, N, N + 3);
    end
  endtask

  task automatic test_random_ready();
    load_mem(2);
    run_op(1, 0, -1, -1, 0);
    vectors++;
    if (writes !== N || exp_q.size() !== 0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL random_ready: got writes=%0d left=%0d done=%0d expected %0d 0 1",
               writes, exp_q.size(), done_cnt, N);
    end
  endtask

  task automatic test_stall();
    load_mem(2);
    run_op(2, 100, -1, -1, 0);
    vectors++;
    if (stall_late_reads !== 0) begin
      miscompares++;
      $display("FAIL stall_reads: got %0d reads during stall expected 0", stall_late_reads);
    end
    vectors++;
    if (stall_out !== 2) begin
      miscompares++;
      $display("FAIL stall_outstanding: got %0d expected 2", stall_out);
    end
    vectors++;
    if (done_rel !== N + 53 || writes !== N) begin
      miscompares++;
      $display("FAIL stall_done: got t=%0d writes=%0d expected %0d %0d", done_rel, writes, N + 53, N);
    end
  endtask

  task automatic test_start_ignored();
    load_mem(2);
    run_op(0, 0, 5, N + 3, 0);
    vectors++;
    if (done_rel !== N + 3 || writes !== N || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL start_ignored: got t=%0d writes=%0d done=%0d expected %0d %0d 1",
               done_rel, writes, done_cnt, N + 3, N);
    end
    do_cycle(1'b1, 1'b0);
    vectors++;
    if ({obs_busy, obs_rd_en, obs_done} !== 3'b0) begin
      miscompares++;
      $display("FAIL after_done: got busy/rd_en/done=%b expected 000", {obs_busy, obs_rd_en, obs_done});
    end
    load_mem(0);
    run_op(0, 0, -1, -1, 0);
    vectors++;
    if (done_rel !== N + 3 || writes !== N) begin
      miscompares++;
      $display("FAIL restart: got t=%0d writes=%0d expected %0d %0d", done_rel, writes, N + 3, N);
    end
  endtask

  task automatic test_reset_mid();
    load_mem(2);
    run_op(0, 0, -1, -1, 300);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, rd_en, wr_valid} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got flags=%b rd_addr=%0d wr_addr=%0d wr_data=%0d expected all 0",
               {busy, done, rd_en, wr_valid}, rd_addr, wr_addr, wr_data);
    end
    pend = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_mem(2);
    run_op(0, 0, -1, -1, 0);
    vectors++;
    if (done_rel !== N + 3 || writes !== N || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_restart: got t=%0d writes=%0d left=%0d expected %0d %0d 0",
               done_rel, writes, exp_q.size(), N + 3, N);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; pend = 1'b0; prev_stall = 1'b0;
    prev_addr = '0; prev_data = '0; first_wv_rel = -1; start_cyc = 0;
    reads = 0; writes = 0; exp_rd_addr = 0; done_cnt = 0; done_rel = -1;
    test_reset();
    test_ramp();
    test_wrap();
    test_random_ready();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
